// File: rtl/func_arbiter.sv
// Purpose: four-way round-robin arbiter that feeds one shared func unit (y = a^3 + floor(sqrt(b))).
// Latency: grant edge to done_o is func busy time + a fixed START/WAIT/DONE overhead; one IDLE cycle between jobs.
// Backpressure: req_i is sampled only in IDLE; a job waits on fn_busy_i (bounded only when FUNC_ARB_TIMEOUT_EN is defined).
module func_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] a_bi,
    input  logic [31:0] b_bi,
    output logic [3:0]  gnt_o,
    output logic [3:0]  done_o,
    output logic [24:0] y_bo,
    output logic        err_o,
    output logic        busy_o,
    output logic        fn_rst_o,
    output logic        fn_start_o,
    output logic [7:0]  fn_a_bo,
    output logic [7:0]  fn_b_bo,
    input  logic        fn_busy_i,
    input  logic [24:0] fn_y_bi
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The timeout limit must fit the 8-bit WAIT counter and be non-zero.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("func_arbiter: TIMEOUT_CYCLES out of range 1..255");
    end

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  win_q, win_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [24:0] y_q, y_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [1:0]  pick;

`ifdef FUNC_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // Round-robin search: first requester at or after ptr_q, wrapping mod 4.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic: pulse outputs default low, everything else holds.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        y_d     = y_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef FUNC_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    // Operands are captured here so later changes on a_bi/b_bi are ignored.
                    win_d   = pick;
                    a_d     = a_bi[{pick, 3'b000} +: 8];
                    b_d     = b_bi[{pick, 3'b000} +: 8];
                    gnt_d   = 4'b0001 << pick;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef FUNC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (!fn_busy_i) begin
                    y_d     = fn_y_bi;
                    done_d  = 4'b0001 << win_q;
                    state_d = S_DONE;
                end
`ifdef FUNC_ARB_TIMEOUT_EN
                else if (cnt_q + 8'd1 == TO_LIMIT) begin
                    // Abort: report an error result of zero to the waiting requester.
                    y_d     = '0;
                    done_d  = 4'b0001 << win_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                // DONE: the serviced requester drops to the back of the rotation.
                ptr_d   = win_q + 2'd1;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset discards any job in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef FUNC_ARB_TIMEOUT_EN
    // WAIT-state watchdog counter and abort flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign y_bo       = y_q;
    assign busy_o     = busy_q;
    assign fn_start_o = start_q;
    assign fn_a_bo    = a_q;
    assign fn_b_bo    = b_q;
    // The func unit is held in reset alongside the arbiter, without a clock delay.
    assign fn_rst_o   = ~rst_i;

endmodule

// File: doc/func_arbiter.md
FUNC_ARBITER -- requirements
Module: func_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, WAIT-state cycle limit before abort (range 1..255); used only with FUNC_ARB_TIMEOUT_EN.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  4  per-requester request level, bit i = requester i.
REQ-005 a_bi  input  32  operand a per requester; requester i on bits [8i+7:8i].
REQ-006 b_bi  input  32  operand b per requester; same packing as a_bi.
REQ-007 gnt_o  output  4  one-hot grant; operands of that requester captured.
REQ-008 done_o  output  4  one-hot, one-cycle result-valid pulse to the granted requester.
REQ-009 y_bo  output  25  result of last completed job, held until next completion.
REQ-010 err_o  output  1  high with done_o when the job was aborted by timeout.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 fn_rst_o  output  1  active-high reset to func unit, combinational ~rst_i.
REQ-013 fn_start_o, fn_a_bo[7:0], fn_b_bo[7:0]  outputs  drive func start_i, a_bi, b_bi.
REQ-014 fn_busy_i[1], fn_y_bi[24:0]  inputs  from func busy_o, y_bo (y = a^3 + floor(sqrt(b))).

Function
REQ-015 FSM states IDLE, START, WAIT, DONE; all outputs except fn_rst_o are registered.
REQ-016 IDLE: at an edge with req_i != 0, select winner by round-robin from pointer ptr (search ptr, ptr+1, ... mod 4), latch its a/b into fn_a_bo/fn_b_bo, go START.
REQ-017 IDLE with req_i == 0: remain IDLE, all pulse outputs low.
REQ-018 START lasts exactly one cycle: fn_start_o = 1 and gnt_o = one-hot winner for that cycle only; next state WAIT.
REQ-019 WAIT: at each edge, if fn_busy_i == 0, capture fn_y_bi into y_bo and go DONE; otherwise stay.
REQ-020 DONE lasts one cycle: done_o = one-hot winner, err_o as per REQ-027; ptr <= winner+1 mod 4; next state IDLE.
REQ-021 fn_a_bo/fn_b_bo hold constant from START through DONE; req_i and operand changes after capture are ignored.
REQ-022 req_i sampled only in IDLE; a requester still requesting after its done_o is eligible again, behind others per ptr.
REQ-023 Minimum job latency: grant edge to done_o = func latency + 3 cycles; one IDLE cycle between jobs.

Reset
REQ-024 rst_i low forces immediately: state IDLE, ptr 0, gnt_o 0, done_o 0, y_bo 0, err_o 0, busy_o 0, fn_start_o 0, fn_a_bo 0, fn_b_bo 0, timeout counter 0.
REQ-025 Reset mid-job discards the job without done_o; fn_rst_o resets the func unit concurrently.

Configuration
REQ-026 Macro FUNC_ARB_TIMEOUT_EN compiles in an 8-bit WAIT cycle counter, cleared on entering WAIT.
REQ-027 With macro: if counter reaches TIMEOUT_CYCLES while fn_busy_i is high, go DONE with y_bo = 0 and err_o = 1; normal completion gives err_o = 0.
REQ-028 Without macro: no counter, WAIT waits indefinitely, err_o tied 0.

Verification
REQ-029 After reset, req_i=4'b0100, requester 2 a=2 b=10 -> gnt_o=4'b0100 for one cycle, then done_o=4'b0100, y_bo=11, err_o=0.
REQ-030 req_i=4'b1111 held, slot operands (255,255),(16,143),(43,11),(54,11) -> done_o order 0,1,2,3 with y_bo 16581390, 4107, 79510, 157467.
REQ-031 After requester 1 serviced (ptr=2), req_i=4'b0011 -> grant goes to requester 0, then requester 1.
REQ-032 Operands of requester 0 changed to (0,0) one cycle after grant of (100,100) -> y_bo=1000010.
REQ-033 rst_i low for one cycle during WAIT -> all outputs 0 immediately, fn_rst_o=1, no done_o; next job (1,1) returns y_bo=2.
REQ-034 FUNC_ARB_TIMEOUT_EN defined, fn_busy_i stubbed high -> done_o after 255 WAIT cycles with err_o=1, y_bo=0, then IDLE.
